// File: rtl/decoder_pkg.sv
// Shared widths, types and a reference one-hot helper for the 3-to-8 decoder slice.
package decoder_pkg;

  localparam int unsigned DEC_IN_W  = 3;
  localparam int unsigned DEC_OUT_W = 8;

  typedef logic [DEC_IN_W-1:0]  dec_addr_t;
  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

  // Generic one-hot builder for callers that need a decode outside the core.
  function automatic dec_onehot_t onehot_of(input dec_addr_t addr);
    dec_onehot_t v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Purely combinational enable-gated 3-to-8 decode.
module decoder_3to8_core
  import decoder_pkg::*;
(
  input  logic [DEC_IN_W-1:0]  A,
  input  logic                 E,
  output logic [DEC_OUT_W-1:0] Y_comb
);

  dec_onehot_t dec;

  always_comb begin
    dec = '0;
    case (A)
      3'd0:    dec = 8'b0000_0001;
      3'd1:    dec = 8'b0000_0010;
      3'd2:    dec = 8'b0000_0100;
      3'd3:    dec = 8'b0000_1000;
      3'd4:    dec = 8'b0001_0000;
      3'd5:    dec = 8'b0010_0000;
      3'd6:    dec = 8'b0100_0000;
      3'd7:    dec = 8'b1000_0000;
      default: dec = '0;
    endcase
  end

  assign Y_comb = E ? dec : '0;

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 decoder: wraps the combinational core with the output
// register, the valid flop and the asynchronous active-high reset.
module decoder_3to8
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W    = 3,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  A,
  input  logic             E,
  output logic [OUT_W-1:0] Y,
  output logic             valid
);

  if (OUT_W != (32'd1 << IN_W)) begin : g_bad_out_w
    $error("decoder_3to8: OUT_W must equal 2**IN_W");
  end
  if (IN_W != DEC_IN_W) begin : g_bad_in_w
    $error("decoder_3to8: decode core supports IN_W == 3 only");
  end

  logic [OUT_W-1:0] y_comb;
  logic             valid_d;
  logic             valid_q;

  decoder_3to8_core u_core (
    .A      (A),
    .E      (E),
    .Y_comb (y_comb)
  );

  always_comb begin
    valid_d = E;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  assign valid = valid_q;

  if (REG_OUT != 0) begin : g_reg
    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_q;

    always_comb begin
      y_d = y_comb;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) y_q <= '0;
      else     y_q <= y_d;
    end

    assign Y = y_q;
  end else begin : g_comb
    // Pass-through still honours reset so Y stays low while rst is held.
    assign Y = rst ? '0 : y_comb;
  end

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed + random bench for decoder_3to8 with a queue-based scoreboard.
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] A;
  logic       E;
  logic [7:0] Y;
  logic       valid;

  typedef struct packed {
    logic       v;
    logic [7:0] y;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  decoder_3to8 #(
    .IN_W    (3),
    .OUT_W   (8),
    .REG_OUT (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .E     (E),
    .Y     (Y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] a, input logic e);
    exp_t r;
    r.v = e;
    r.y = e ? (8'h01 << a) : 8'h00;
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] oy, input logic ov,
                       input logic [7:0] ey, input logic ev);
    n_checks++;
    assert ({ov, oy} === {ev, ey}) else begin
      n_fail++;
      $error("FAIL %s: observed Y=%h valid=%b expected Y=%h valid=%b", tag, oy, ov, ey, ev);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic e);
    A = a;
    E = e;
    sb.push_back(model(a, e));
  endtask

  task automatic sample(input string tag);
    exp_t ex;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed Y=%h valid=%b", tag, Y, valid);
    end else begin
      ex = sb.pop_front();
      check(tag, Y, valid, ex.y, ex.v);
    end
  endtask

  task automatic step(input logic [2:0] a, input logic e, input string tag);
    @(negedge clk);
    drive(a, e);
    @(posedge clk);
    #1;
    sample(tag);
  endtask

  // One-hot invariant and its tie to valid, checked every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      assert (($countones(Y) <= 1) && (($countones(Y) == 1) == (valid == 1'b1))) else begin
        n_fail++;
        $error("FAIL onehot_mon: observed Y=%h valid=%b expected popcount<=1 and popcount==valid", Y, valid);
      end
    end
  end

  initial begin
    rst = 1'b1;
    A   = 3'd0;
    E   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_init", Y, valid, 8'h00, 1'b0);
    mon_en = 1'b1;

    @(negedge clk);
    rst = 1'b0;
    step(3'd5, 1'b1, "post_init");

    // Async reset mid-cycle with the low phase of clk: no edge involved.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", Y, valid, 8'h00, 1'b0);
    sb.delete();
    @(posedge clk);
    #1;
    check("reset_hold", Y, valid, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'd5, 1'b1);
    @(posedge clk);
    #1;
    sample("rst_release");

    for (int i = 0; i < 8; i++) step(3'(i), 1'b0, $sformatf("dis_sweep_%0d", i));
    for (int i = 0; i < 8; i++) step(3'(i), 1'b1, $sformatf("en_sweep_%0d", i));

    step(3'd3, 1'b0, "toggle_lo0");
    step(3'd3, 1'b1, "toggle_hi");
    step(3'd3, 1'b0, "toggle_lo1");

    step(3'd7, 1'b1, "b2b_a7");
    step(3'd0, 1'b1, "b2b_a0");
    step(3'd6, 1'b0, "simul_change_off");
    step(3'd2, 1'b1, "simul_change_on");

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        A   = 3'($urandom_range(0, 7));
        E   = 1'($urandom_range(0, 1));
        #1;
        check("rnd_async_reset", Y, valid, 8'h00, 1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        check("rnd_reset_hold", Y, valid, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        @(posedge clk);
        #1;
        sample("rnd_rst_release");
      end else begin
        step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rnd");
      end
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
